// File: rtl/mfp_pump_scheduler_pkg.sv
// mfp_pump_pkg: state encoding, register map and control bit positions for the pump scheduler
package mfp_pump_pkg;
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_OPEN   = 3'd1;
   localparam logic [2:0] ST_PUMP   = 3'd2;
   localparam logic [2:0] ST_CLOSE  = 3'd3;
   localparam logic [2:0] ST_SETTLE = 3'd4;
   localparam logic [2:0] ADDR_MASK   = 3'd0;
   localparam logic [2:0] ADDR_MAX_ON = 3'd1;
   localparam logic [2:0] ADDR_GUARD  = 3'd2;
   localparam logic [2:0] ADDR_CTRL   = 3'd3;
   localparam logic [2:0] ADDR_STAT0  = 3'd4;
   localparam int CTRL_EN   = 0;
   localparam int CTRL_STOP = 1;
   localparam int CTRL_CLR  = 2;
   localparam int GUARD_RST = 10;
endpackage

// File: rtl/mfp_pump_scheduler_rr_arbiter.sv
// mfp_rr_arbiter: combinational round-robin find-first from ptr upward with wrap
module mfp_rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0] req,
   input  logic [2:0]   ptr,
   output logic [N-1:0] grant,
   output logic [2:0]   idx
);
   logic [N-1:0] ge, hi, pick;
   // requests at or above ptr win; otherwise wrap to the lowest request
   assign ge    = ~((N'(1) << ptr) - N'(1));
   assign hi    = req & ge;
   assign pick  = |hi ? hi : req;
   assign grant = pick & (~pick + N'(1));
   always_comb begin
      idx = '0;
      for (int i = 0; i < N; i++)
         if (grant[i]) idx = 3'(i);
   end
endmodule

// File: rtl/mfp_pump_scheduler.sv
// mfp_pump_scheduler: round-robin pump/valve sequencer with register port; MFP_PUMP_SCHED_STATS_EN adds served counters
module mfp_pump_scheduler
   import mfp_pump_pkg::*;
#(
   parameter int N_ZONES  = 4,
   parameter int TICK_DIV = 50000,
   parameter int TW       = 16
) (
   input  logic               HCLK,
   input  logic               SI_Reset,
   input  logic [N_ZONES-1:0] zone_req,
   input  logic               cfg_we,
   input  logic [2:0]         cfg_addr,
   input  logic [TW-1:0]      cfg_wdata,
   output logic [TW-1:0]      cfg_rdata,
   output logic [N_ZONES-1:0] valve_en,
   output logic               pump_en,
   output logic [2:0]         active_zone,
   output logic               busy,
   output logic [N_ZONES-1:0] zone_done
);
   localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
   logic [2:0]         state, nxt, rr_ptr, gnt_idx;
   logic [N_ZONES-1:0] mask, elig, gnt, flags, act_oh;
   logic [TW-1:0]      max_on, guard, cur_guard, tick_cnt, stat_rd;
   logic [PW-1:0]      pre;
   logic               global_en, wr_ctrl, force_stop, clr_flags, held;
   logic               pre_last, guard_done, max_done, set_flag;
   assign elig       = zone_req & mask & {N_ZONES{global_en}};
   assign act_oh     = N_ZONES'(1) << active_zone;
   assign wr_ctrl    = cfg_we && cfg_addr == ADDR_CTRL;
   assign force_stop = wr_ctrl && cfg_wdata[CTRL_STOP];
   assign clr_flags  = wr_ctrl && cfg_wdata[CTRL_CLR];
   assign held       = |(elig & act_oh) && !force_stop;
   assign pre_last   = pre == PW'(TICK_DIV - 1);
   assign guard_done = cur_guard == '0 || (pre_last && tick_cnt == cur_guard - TW'(1));
   // >= lets a MAX_ON lowered mid-run below the elapsed time end the pump at once
   assign max_done   = max_on != '0 && (tick_cnt >= max_on || (pre_last && tick_cnt == max_on - TW'(1)));
   mfp_rr_arbiter #(.N(N_ZONES)) u_arb (
      .req   (elig),
      .ptr   (rr_ptr),
      .grant (gnt),
      .idx   (gnt_idx)
   );
   always_comb begin
      nxt      = state;
      set_flag = 1'b0;
      case (state)
         ST_IDLE:   nxt = |gnt ? ST_OPEN : ST_IDLE;
         ST_OPEN:   nxt = !held ? ST_CLOSE : guard_done ? ST_PUMP : ST_OPEN;
         ST_PUMP: begin
            set_flag = max_done;
            nxt      = (!held || max_done) ? ST_CLOSE : ST_PUMP;
         end
         ST_CLOSE:  nxt = guard_done ? ST_SETTLE : ST_CLOSE;
         ST_SETTLE: nxt = guard_done ? ST_IDLE : ST_SETTLE;
         default:   nxt = ST_IDLE;
      endcase
   end
   always_ff @(posedge HCLK) begin
      if (SI_Reset) begin
         state       <= ST_IDLE;
         rr_ptr      <= '0;
         active_zone <= '0;
         zone_done   <= '0;
         flags       <= '0;
         mask        <= '1;
         max_on      <= '0;
         guard       <= TW'(GUARD_RST);
         cur_guard   <= TW'(GUARD_RST);
         global_en   <= 1'b0;
         pre         <= '0;
         tick_cnt    <= '0;
      end else begin
         state       <= nxt;
         zone_done   <= (state == ST_CLOSE && nxt == ST_SETTLE) ? act_oh : '0;
         active_zone <= (state == ST_IDLE && |gnt) ? gnt_idx : active_zone;
         rr_ptr      <= (state == ST_CLOSE && nxt == ST_SETTLE) ?
                        (active_zone == 3'(N_ZONES - 1) ? 3'd0 : active_zone + 3'd1) : rr_ptr;
         flags       <= (clr_flags ? '0 : flags) | (set_flag ? act_oh : '0);
         mask        <= (cfg_we && cfg_addr == ADDR_MASK) ? cfg_wdata[N_ZONES-1:0] : mask;
         max_on      <= (cfg_we && cfg_addr == ADDR_MAX_ON) ? cfg_wdata : max_on;
         guard       <= (cfg_we && cfg_addr == ADDR_GUARD) ? cfg_wdata : guard;
         global_en   <= wr_ctrl ? cfg_wdata[CTRL_EN] : global_en;
         // timebase restarts on every state entry; GUARD is captured there too
         cur_guard   <= (nxt != state) ? guard : cur_guard;
         pre         <= (nxt != state || pre_last) ? '0 : pre + PW'(1);
         tick_cnt    <= (nxt != state) ? '0 :
                        (pre_last && tick_cnt != '1) ? tick_cnt + TW'(1) : tick_cnt;
      end
   end
   assign busy     = state != ST_IDLE;
   assign pump_en  = state == ST_PUMP;
   assign valve_en = (state == ST_OPEN || state == ST_PUMP || state == ST_CLOSE) ? act_oh : '0;
   assign cfg_rdata = cfg_addr >= ADDR_STAT0   ? stat_rd :
                      cfg_addr == ADDR_MASK    ? TW'(mask) :
                      cfg_addr == ADDR_MAX_ON  ? max_on :
                      cfg_addr == ADDR_GUARD   ? guard :
                      TW'({8'(flags), 1'b0, state, active_zone, global_en});
`ifdef MFP_PUMP_SCHED_STATS_EN
   localparam int NS = N_ZONES < 4 ? N_ZONES : 4;
   logic [TW-1:0] served [NS];
   always_ff @(posedge HCLK) begin
      for (int z = 0; z < NS; z++)
         if (SI_Reset || (cfg_we && cfg_addr == ADDR_STAT0 + 3'(z))) served[z] <= '0;
         else if (zone_done[z] && served[z] != '1) served[z] <= served[z] + TW'(1);
   end
   assign stat_rd = int'(cfg_addr[1:0]) < NS ? served[cfg_addr[1:0]] : '0;
`else
   assign stat_rd = '0;
`endif
endmodule

// File: tb/tb_mfp_pump_scheduler.sv
// tb_mfp_pump_scheduler: register vectors plus grant/done scoreboard for the pump scheduler
module tb_mfp_pump_scheduler;
   logic        HCLK = 1'b0, SI_Reset = 1'b1, cfg_we = 1'b0;
   logic [3:0]  zone_req = '0;
   logic [2:0]  cfg_addr = '0;
   logic [15:0] cfg_wdata = '0;
   logic [15:0] cfg_rdata;
   logic [3:0]  valve_en, zone_done;
   logic        pump_en, busy;
   logic [2:0]  active_zone;
   int          total = 0, bad = 0, valve_run = 0;
   logic [3:0]  sb[$], vq[$];
   logic [3:0]  prev_valve = '0;
   logic        prev_pump = 1'b0, awaiting = 1'b0;
`ifdef MFP_PUMP_SCHED_STATS_EN
   localparam logic [15:0] EXP5 = 16'd3;
`else
   localparam logic [15:0] EXP5 = 16'd0;
`endif
   typedef struct {
      bit          we;
      logic [2:0]  addr;
      logic [15:0] wdata;
      logic [15:0] exp;
   } vec_t;
   vec_t vecs[12];

   mfp_pump_scheduler #(.N_ZONES(4), .TICK_DIV(4), .TW(16)) dut (
      .HCLK        (HCLK),
      .SI_Reset    (SI_Reset),
      .zone_req    (zone_req),
      .cfg_we      (cfg_we),
      .cfg_addr    (cfg_addr),
      .cfg_wdata   (cfg_wdata),
      .cfg_rdata   (cfg_rdata),
      .valve_en    (valve_en),
      .pump_en     (pump_en),
      .active_zone (active_zone),
      .busy        (busy),
      .zone_done   (zone_done)
   );

   always #5 HCLK = ~HCLK;

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
      end
   endtask

   // per-cycle checks: grant order, done order, one valve, guard before pump, pump off before valve
   task automatic mon();
      logic [3:0] e;
      if (zone_done != 0) begin
         if (sb.size() == 0) chk("done_unexpected", 16'(zone_done), 16'h0);
         else begin
            e = sb.pop_front();
            chk("done_order", 16'(zone_done), 16'(e));
         end
         awaiting = 1'b0;
      end
      if (valve_en != 0 && prev_valve == 0) begin
         chk("done_before_grant", 16'(awaiting), 16'h0);
         if (vq.size() == 0) chk("grant_unexpected", 16'(valve_en), 16'h0);
         else begin
            e = vq.pop_front();
            chk("grant_order", 16'(valve_en), 16'(e));
         end
         awaiting = 1'b1;
      end
      valve_run = (valve_en != 0 && valve_en == prev_valve) ? valve_run + 1 : (valve_en != 0 ? 1 : 0);
      chk("invariant", 16'(($countones(valve_en) <= 1) && (!pump_en || valve_run >= 9) &&
                           (SI_Reset || !prev_pump || valve_en != 0)), 16'h1);
      prev_valve = valve_en;
      prev_pump  = pump_en;
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge HCLK);
         #1;
         mon();
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      step(1);
      cfg_we = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string name);
      cfg_addr = a;
      #1;
      chk(name, cfg_rdata, exp);
   endtask

   task automatic do_reset(input string tag);
      SI_Reset = 1'b1; cfg_we = 1'b0; zone_req = '0;
      step(2);
      SI_Reset = 1'b0;
      awaiting = 1'b0;
      chk({tag, "_out"}, 16'({busy, pump_en, valve_en, zone_done, active_zone}), 16'h0);
      rd(3'd0, 16'h000F, {tag, "_mask"});
      rd(3'd1, 16'h0000, {tag, "_maxon"});
      rd(3'd2, 16'h000A, {tag, "_guard"});
      rd(3'd3, 16'h0000, {tag, "_ctrl"});
   endtask

   task automatic wait_pump(input string name);
      int n = 0;
      while (!pump_en && n < 100) begin step(1); n++; end
      chk(name, 16'(pump_en), 16'h1);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 100) begin step(1); n++; end
      chk(name, 16'(busy), 16'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int n, cnt;
      vecs[0]  = '{1'b1, 3'd0, 16'h0005, 16'h0005};
      vecs[1]  = '{1'b1, 3'd0, 16'hFFFF, 16'h000F};
      vecs[2]  = '{1'b1, 3'd1, 16'h0007, 16'h0007};
      vecs[3]  = '{1'b1, 3'd2, 16'h0003, 16'h0003};
      vecs[4]  = '{1'b1, 3'd3, 16'h0001, 16'h0001};
      vecs[5]  = '{1'b1, 3'd3, 16'h0004, 16'h0000};
      vecs[6]  = '{1'b0, 3'd4, 16'h0000, 16'h0000};
      vecs[7]  = '{1'b0, 3'd6, 16'h0000, 16'h0000};
      vecs[8]  = '{1'b0, 3'd7, 16'h0000, 16'h0000};
      vecs[9]  = '{1'b1, 3'd1, 16'h0000, 16'h0000};
      vecs[10] = '{1'b1, 3'd2, 16'h0002, 16'h0002};
      vecs[11] = '{1'b1, 3'd3, 16'h0001, 16'h0001};
      do_reset("rst0");
      for (int i = 0; i < 12; i++) begin
         if (vecs[i].we) wr(vecs[i].addr, vecs[i].wdata);
         rd(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
      end

      // single zone: guard, pump, drop, close, settle
      zone_req = 4'b0100; sb.push_back(4'b0100); vq.push_back(4'b0100);
      step(1);
      ok = 1;
      repeat (8) begin ok &= (valve_en == 4'b0100) && !pump_en; step(1); end
      chk("t1_open_8", 16'(ok), 16'h1);
      chk("t1_pump_on", 16'({pump_en, valve_en}), 16'h0014);
      step(3);
      zone_req = '0;
      step(1);
      chk("t1_pump_off", 16'({pump_en, valve_en}), 16'h0004);
      ok = 1;
      repeat (8) begin ok &= (valve_en == 4'b0100) && !pump_en; step(1); end
      chk("t1_close_8", 16'(ok), 16'h1);
      chk("t1_settle", 16'({busy, pump_en, valve_en}), 16'h0020);
      chk("t1_done_pulse", 16'(zone_done), 16'h0004);
      ok = 1;
      repeat (8) begin ok &= busy && valve_en == 0; step(1); end
      chk("t1_settle_8", 16'(ok), 16'h1);
      chk("t1_idle", 16'(busy), 16'h0);

      // round robin over 1011 from rr_ptr 0
      do_reset("rst2");
      wr(3'd2, 16'd2); wr(3'd1, 16'd2); wr(3'd3, 16'h0001);
      zone_req = 4'b1011;
      sb.push_back(4'b0001); sb.push_back(4'b0010); sb.push_back(4'b1000); sb.push_back(4'b0001);
      vq.push_back(4'b0001); vq.push_back(4'b0010); vq.push_back(4'b1000); vq.push_back(4'b0001);
      n = 0;
      while ((sb.size() != 0 || vq.size() != 0) && n < 300) begin step(1); n++; end
      chk("t2_all_served", 16'(sb.size() + vq.size()), 16'h0);
      zone_req = '0;
      wait_idle("t2_idle");
      rd(3'd3, 16'h0B01, "t2_flags");
      wr(3'd3, 16'h0005);
      rd(3'd3, 16'h0001, "t2_flags_clr");

      // MAX_ON timeout
      wr(3'd1, 16'd5);
      zone_req = 4'b0010; sb.push_back(4'b0010); vq.push_back(4'b0010);
      wait_pump("t3_pump_rise");
      cnt = 0;
      while (pump_en && cnt < 100) begin cnt++; step(1); end
      chk("t3_pump_len", 16'(cnt), 16'd20);
      zone_req = '0;
      wait_idle("t3_idle");
      rd(3'd3, 16'h0203, "t3_flag");
      wr(3'd3, 16'h0005);
      rd(3'd3, 16'h0003, "t3_flag_clr");
      wr(3'd1, 16'd0);

      // force_stop in PUMP, then request drop in OPEN
      zone_req = 4'b0100; sb.push_back(4'b0100); vq.push_back(4'b0100);
      wait_pump("t4_pump_rise");
      step(2);
      wr(3'd3, 16'h0003);
      chk("t4_stop", 16'({pump_en, valve_en}), 16'h0004);
      zone_req = '0;
      wait_idle("t4_idle");
      rd(3'd3, 16'h0005, "t4_ctrl");
      zone_req = 4'b1000; sb.push_back(4'b1000); vq.push_back(4'b1000);
      step(3);
      chk("t4b_open", 16'({pump_en, valve_en}), 16'h0008);
      zone_req = '0;
      ok = 0; n = 0;
      while (busy && n < 100) begin ok |= pump_en; step(1); n++; end
      chk("t4b_no_pump", 16'(ok), 16'h0);
      chk("t4b_idle", 16'(busy), 16'h0);

      // reset mid-PUMP
      wr(3'd1, 16'd9); wr(3'd0, 16'h0007);
      zone_req = 4'b0001; vq.push_back(4'b0001);
      wait_pump("t5_pump_rise");
      step(2);
      SI_Reset = 1'b1;
      step(1);
      chk("t5_out", 16'({busy, pump_en, valve_en, zone_done}), 16'h0);
      chk("t5_active", 16'(active_zone), 16'h0);
      SI_Reset = 1'b0; awaiting = 1'b0; zone_req = '0;
      rd(3'd0, 16'h000F, "t5_mask");
      rd(3'd1, 16'h0000, "t5_maxon");
      rd(3'd2, 16'h000A, "t5_guard");
      rd(3'd3, 16'h0000, "t5_ctrl");
      step(2);
      chk("t5_stay_idle", 16'(busy), 16'h0);

      // served counters
      do_reset("rst6");
      wr(3'd2, 16'd2); wr(3'd3, 16'h0001);
      for (int k = 0; k < 3; k++) begin
         zone_req = 4'b0010; sb.push_back(4'b0010); vq.push_back(4'b0010);
         wait_pump($sformatf("t6_pump%0d", k));
         zone_req = '0;
         wait_idle($sformatf("t6_idle%0d", k));
      end
      rd(3'd5, EXP5, "t6_stat5");
      rd(3'd4, 16'h0000, "t6_stat4");
      wr(3'd5, 16'h1234);
      rd(3'd5, 16'h0000, "t6_stat5_clr");

      chk("scoreboard_empty", 16'(sb.size() + vq.size()), 16'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
